alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_res_fifo.sv | 80 ++++++++
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller and its result FIFO.
//   SEL_*   : operation select encodings driven to the external ALU
//   state_t : issue controller FSM states
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_2   = 2'b10;
   localparam logic [1:0] SEL_3   = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

endpackage

// File: rtl/alu_res_fifo.sv
// ---------------------------------------------------------------------------
// alu_res_fifo
// Circular result buffer holding {select, carry, result} words in arrival
// order.
//   clk, rst_n : clock and asynchronous active-low reset
//   push_i     : write wdata_i at the tail (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   wdata_i    : entry to write
//   rdata_o    : oldest entry (meaningful only while count_o != 0)
//   count_o    : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap on their own.
// ---------------------------------------------------------------------------
module alu_res_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 7,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q;
   logic [PW-1:0]    rdPtr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             doPush;
   logic             doPop;

   // Qualify the raw requests so a pop on an empty buffer or a push on a
   // full one never moves a pointer.
   assign doPush = push_i && (count_q != CW'(DEPTH));
   assign doPop  = pop_i && (count_q != '0);

   // Occupancy only changes when exactly one of push/pop happens; a
   // simultaneous push and pop leaves it where it was.
   always_comb begin
      count_d = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + CW'(1);
      end else if (!doPush && doPop) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointers and count are the only state that reset has to clear; stale
   // storage contents are unreachable once the count is zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + PW'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

   // Storage is written without reset so it can map onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rdPtr_q];
   assign count_o = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issues operation requests to an external combinational ALU, one every two
// cycles, and buffers the returned results in a FIFO for the consumer.
//   clk, rst_n            : clock and asynchronous active-low reset
//   in_valid / in_ready   : request handshake
//   in_a, in_b, in_s      : operands and operation select
//   alu_a, alu_b, alu_s   : registered drive into the external ALU
//   alu_out, alu_cout     : combinational result and carry from the ALU
//   out_valid / out_ready : result handshake
//   out_data, out_carry,
//   out_s                 : oldest buffered result, carry and select
// Optional feature (macro ALU_ISSUE_STATS_EN):
//   op_count, carry_count : 16-bit wrapping counts of results written and of
//                           results written with carry set
// ---------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [1:0]   in_s,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_s,
   input  logic [W-1:0] alu_out,
   input  logic         alu_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_carry,
   output logic [1:0]   out_s
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [15:0]  op_count,
   output logic [15:0]  carry_count
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int FW = W + 3;

   state_t          state_q;
   logic [W-1:0]    aluA_q;
   logic [W-1:0]    aluB_q;
   logic [1:0]      aluS_q;
   logic [CW-1:0]   fifoCount;
   logic            fifoPush;
   logic            fifoPop;
   logic [FW-1:0]   fifoWdata;
   logic [FW-1:0]   fifoRdata;

   // A request is only taken when no operation is in flight and a FIFO slot
   // is already free, so the result written during EXEC can never overflow.
   assign in_ready = (state_q == IDLE) && (fifoCount < CW'(DEPTH));

   // Issue FSM. The ALU operand registers only load on acceptance, so the
   // external ALU sees stable inputs for the whole EXEC cycle and while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         aluA_q  <= '0;
         aluB_q  <= '0;
         aluS_q  <= SEL_ADD;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  aluA_q  <= in_a;
                  aluB_q  <= in_b;
                  aluS_q  <= in_s;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign alu_a = aluA_q;
   assign alu_b = aluB_q;
   assign alu_s = aluS_q;

   // The ALU result is captured at the end of the EXEC cycle together with
   // the select that produced it, so the consumer can tell operations apart.
   assign fifoPush  = (state_q == EXEC);
   assign fifoPop   = out_valid && out_ready;
   assign fifoWdata = {aluS_q, alu_cout, alu_out};

   alu_res_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) uResFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifoPush),
      .pop_i   (fifoPop),
      .wdata_i (fifoWdata),
      .rdata_o (fifoRdata),
      .count_o (fifoCount)
   );

   assign out_valid = (fifoCount != '0);
   assign out_data  = fifoRdata[W-1:0];
   assign out_carry = fifoRdata[W];
   assign out_s     = fifoRdata[W+2:W+1];

`ifdef ALU_ISSUE_STATS_EN
   logic [15:0] opCount_q;
   logic [15:0] carryCount_q;

   // Statistics follow FIFO writes, not acceptances, so an operation killed
   // by reset before its result lands is never counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opCount_q    <= '0;
         carryCount_q <= '0;
      end else if (fifoPush) begin
         opCount_q <= opCount_q + 16'd1;
         if (alu_cout) begin
            carryCount_q <= carryCount_q + 16'd1;
         end
      end
   end

   assign op_count    = opCount_q;
   assign carry_count = carryCount_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl with a transaction-level model of
// the controller and a behavioural stand-in for the external ALU.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   localparam int DEPTH = 4;
   localparam int W     = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [1:0]   in_s;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [1:0]   alu_s;
   logic [W-1:0] alu_out;
   logic         alu_cout;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_carry;
   logic [1:0]   out_s;
`ifdef ALU_ISSUE_STATS_EN
   logic [15:0]  op_count;
   logic [15:0]  carry_count;
`endif

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;
   int lastAccept = 0;

   alu_issue_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_s        (in_s),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_s       (alu_s),
      .alu_out     (alu_out),
      .alu_cout    (alu_cout),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_carry   (out_carry),
      .out_s       (out_s)
`ifdef ALU_ISSUE_STATS_EN
      ,
      .op_count    (op_count),
      .carry_count (carry_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU behaviour: add, subtract with carry meaning "no borrow",
   // AND and XOR. Returns {carry, result}.
   function automatic logic [W:0] aluRef(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [1:0] s);
      logic [W:0] r;
      case (s)
         2'b00:   r = {1'b0, a} + {1'b0, b};
         2'b01:   r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
         2'b10:   r = {1'b0, a & b};
         default: r = {1'b0, a ^ b};
      endcase
      return r;
   endfunction

   // External combinational ALU driven by the DUT's registered operands.
   assign {alu_cout, alu_out} = aluRef(alu_a, alu_b, alu_s);

   // Transaction-level model: one operation may be in flight; its result
   // joins the queue of expected outputs one cycle after acceptance.
   typedef struct packed {
      logic [1:0]   s;
      logic         c;
      logic [W-1:0] d;
   } res_t;

   res_t         expQ[$];
   bit           mBusy;
   logic [W-1:0] mA;
   logic [W-1:0] mB;
   logic [1:0]   mS;

   function bit mReady();
      return !mBusy && (expQ.size() < DEPTH);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expQ.delete();
         mBusy = 1'b0;
         mA = '0;
         mB = '0;
         mS = '0;
      end else begin
         bit acc;
         res_t r;
         acc = mReady() && in_valid;
         if (expQ.size() != 0 && out_ready) begin
            void'(expQ.pop_front());
         end
         if (mBusy) begin
            {r.c, r.d} = aluRef(mA, mB, mS);
            r.s = mS;
            expQ.push_back(r);
            mBusy = 1'b0;
         end else if (acc) begin
            mA = in_a;
            mB = in_b;
            mS = in_s;
            mBusy = 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   // Compare process: every mid-cycle the DUT must agree with the model.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("in_ready", in_ready, mReady());
         checkOutput("out_valid", out_valid, expQ.size() != 0);
         checkOutput("alu_a", alu_a, mA);
         checkOutput("alu_b", alu_b, mB);
         checkOutput("alu_s", alu_s, mS);
         if (expQ.size() != 0) begin
            checkOutput("out_data", out_data, expQ[0].d);
            checkOutput("out_carry", out_carry, expQ[0].c);
            checkOutput("out_s", out_s, expQ[0].s);
         end
      end
   end

   // Present one request and wait for it to be accepted; returns #1 after
   // the accepting edge. With keep set, in_valid stays high afterwards.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] s, input bit keep);
      bit accepted;
      accepted = 1'b0;
      in_a = a;
      in_b = b;
      in_s = s;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !accepted; i++) begin
         @(negedge clk);
         accepted = in_ready;
         @(posedge clk);
         #1;
      end
      if (!accepted) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL accept_timeout: got no acceptance, expected one within 50 cycles");
      end else begin
         lastAccept = cyc;
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2 * DEPTH + 4) @(posedge clk);
      #1;
   endtask

   int t[4];
   int p;
   int r;

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_s = '0;
      out_ready = 1'b0;

      // Pin the reference ALU against hand-computed values.
      checkOutput("ref_sub_9_5", aluRef(4'd9, 4'd5, 2'b01), 32'h14);
      checkOutput("ref_sub_3_5", aluRef(4'd3, 4'd5, 2'b01), 32'h0E);
      checkOutput("ref_add_15_1", aluRef(4'd15, 4'd1, 2'b00), 32'h10);
      checkOutput("ref_and_12_10", aluRef(4'd12, 4'd10, 2'b10), 32'h08);

      #2;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_alu_a", alu_a, 0);
      checkOutput("rst_alu_s", alu_s, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single operation: 9 - 5.
      applyStimulus(4'd9, 4'd5, 2'b01, 1'b0);
      @(negedge clk);
      checkOutput("single_early_valid", out_valid, 0);
      @(posedge clk);
      #1;
      checkOutput("single_valid", out_valid, 1);
      checkOutput("single_data", out_data, 4);
      checkOutput("single_carry", out_carry, 1);
      checkOutput("single_s", out_s, 2'b01);
      drain();

      // Back-to-back requests with in_valid held high.
      applyStimulus(4'd1, 4'd2, 2'b00, 1'b1); t[0] = lastAccept;
      applyStimulus(4'd7, 4'd9, 2'b01, 1'b1); t[1] = lastAccept;
      applyStimulus(4'd6, 4'd5, 2'b10, 1'b1); t[2] = lastAccept;
      applyStimulus(4'd3, 4'd3, 2'b11, 1'b0); t[3] = lastAccept;
      for (int k = 1; k < 4; k++) checkOutput("b2b_spacing", t[k] - t[k-1], 2);
      drain();

      // Fill the FIFO, then confirm a single pop re-opens the input.
      out_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) applyStimulus(W'(k), W'(k + 3), 2'(k), 1'b0);
      @(posedge clk);
      #1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("full_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      p = cyc;
      @(negedge clk);
      checkOutput("after_pop_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      p = cyc;
      applyStimulus(4'd2, 4'd2, 2'b00, 1'b0);
      checkOutput("after_pop_accept", lastAccept, p + 1);
      drain();

      // Simultaneous push and pop with two entries buffered.
      out_ready = 1'b0;
      applyStimulus(4'd3, 4'd4, 2'b00, 1'b0);
      applyStimulus(4'd6, 4'd3, 2'b11, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(4'd12, 4'd10, 2'b10, 1'b0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checkOutput("pp_head_data", out_data, 5);
      checkOutput("pp_head_s", out_s, 2'b11);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checkOutput("pp_second_data", out_data, 8);
      checkOutput("pp_second_valid", out_valid, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checkOutput("pp_empty", out_valid, 0);

      // Reset during EXEC with two results buffered.
      applyStimulus(4'd1, 4'd1, 2'b00, 1'b0);
      applyStimulus(4'd2, 4'd1, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(4'd5, 4'd6, 2'b11, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_out_valid", out_valid, 0);
      checkOutput("mid_rst_alu_a", alu_a, 0);
      checkOutput("mid_rst_alu_b", alu_b, 0);
      checkOutput("mid_rst_alu_s", alu_s, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      r = cyc;
      out_ready = 1'b1;
      applyStimulus(4'd8, 4'd1, 2'b01, 1'b0);
      checkOutput("post_rst_accept", lastAccept, r + 1);
      @(negedge clk);
      checkOutput("post_rst_no_stale", out_valid, 0);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_rst_data", out_data, 7);
      checkOutput("post_rst_carry", out_carry, 1);
      drain();

      // Randomized traffic checked by the compare process.
      for (int k = 0; k < 400; k++) begin
         in_valid = ($urandom_range(0, 1) == 1);
         in_a = W'($urandom);
         in_b = W'($urandom);
         in_s = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      drain();

`ifdef ALU_ISSUE_STATS_EN
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      applyStimulus(4'd15, 4'd1, 2'b00, 1'b0);
      applyStimulus(4'd9, 4'd5, 2'b01, 1'b0);
      applyStimulus(4'd1, 4'd2, 2'b00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("stats_op_count", op_count, 3);
      checkOutput("stats_carry_count", carry_count, 2);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
